// File: rtl/game_pkg.sv
// Shared game-flow types: the global game-state encoding used by the
// sequencer, the transition/evolve animation blocks, the pixel mux and
// the gameplay logic.
package game_pkg;

  // One-hot-ish encodings are fixed; downstream blocks decode these bits.
  typedef enum logic [2:0] {
    ST_OVERWORLD  = 3'b001,
    ST_TRANSITION = 3'b010,
    ST_BATTLE     = 3'b100,
    ST_EVOLVE     = 3'b011
  } game_state_t;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;

  // Animation states are the ones guarded by the frame watchdog.
  function automatic logic is_anim_state(game_state_t s);
    return (s == ST_TRANSITION) || (s == ST_EVOLVE);
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Raster-origin edge detector: one registered pulse per frame, on the first
// cycle the raster counters sit at (0,0), however long they stay there.
module frame_tick_gen
  import game_pkg::*;
(
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  output logic                frame_tick_out
);

  logic at_origin;
  logic at_origin_q;

  assign at_origin = (hcount_in == '0) && (vcount_in == '0);

  // Remember the previous origin match and emit a registered rising-edge pulse.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      at_origin_q    <= 1'b0;
      frame_tick_out <= 1'b0;
    end else begin
      at_origin_q    <= at_origin;
      frame_tick_out <= at_origin && !at_origin_q;
    end
  end

endmodule

// File: rtl/game_state_sequencer.sv
// Top-level game-flow controller: overworld -> transition -> battle
// (-> evolve) -> overworld, with start strobes for the animation blocks,
// frame-qualified done inputs and a per-state frame watchdog.
module game_state_sequencer
  import game_pkg::*;
#(
  parameter int unsigned TIMEOUT_FRAMES = 120,
  parameter int unsigned FRAME_CNT_W    = 8
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [10:0]         hcount_in,
  input  logic [9:0]          vcount_in,
  input  logic                encounter_in,
  input  logic                battle_over_in,
  input  logic                evolve_req_in,
  input  logic                trans_done_in,
  input  logic                evo_done_in,
  output logic [2:0]          state_out,
  output logic                trans_start_out,
  output logic                evo_start_out,
  output logic                frame_tick_out,
  output logic                timeout_out
);

  localparam logic [FRAME_CNT_W-1:0] TIMEOUT_CNT = FRAME_CNT_W'(TIMEOUT_FRAMES);

  game_state_t            state_q, state_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic                   evo_pending_q;
  logic                   frame_tick;
  logic                   wd_fire;
  logic                   state_change;
  logic                   cnt_started;
  logic                   cnt_expired;

  frame_tick_gen u_frame_tick_gen (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .frame_tick_out (frame_tick)
  );

  assign frame_tick_out = frame_tick;
  assign state_out      = state_q;

  // A done is only trusted after one full frame in the state, which masks
  // sticky done levels left over from the previous animation run.
  assign cnt_started = (frame_cnt_q != '0);
  assign cnt_expired = (frame_cnt_q == TIMEOUT_CNT);

  // Next-state decode; a qualified done always beats the watchdog.
  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    wd_fire = 1'b0;
    unique case (state_q)
      ST_OVERWORLD: begin
        if (encounter_in) state_d = ST_TRANSITION;
      end
      ST_TRANSITION: begin
        if (trans_done_in && cnt_started) begin
          state_d = ST_BATTLE;
        end else if (cnt_expired) begin
          state_d = ST_BATTLE;
          wd_fire = 1'b1;
        end
      end
      ST_BATTLE: begin
        if (battle_over_in)
          state_d = (evo_pending_q || evolve_req_in) ? ST_EVOLVE : ST_OVERWORLD;
      end
      ST_EVOLVE: begin
        if (evo_done_in && cnt_started) begin
          state_d = ST_OVERWORLD;
        end else if (cnt_expired) begin
          state_d = ST_OVERWORLD;
          wd_fire = 1'b1;
        end
      end
      default: state_d = ST_OVERWORLD;
    endcase
  end

  assign state_change = (state_d != state_q);

  // State register with start strobes registered alongside it, so they are
  // glitch-free decodes that drop on the same edge the done is accepted.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q         <= ST_OVERWORLD;
      trans_start_out <= 1'b0;
      evo_start_out   <= 1'b0;
    end else begin
      state_q         <= state_d;
      trans_start_out <= (state_d == ST_TRANSITION);
      evo_start_out   <= (state_d == ST_EVOLVE);
    end
  end

  // Per-state frame counter: cleared on any state change, saturating.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      frame_cnt_q <= '0;
    end else if (state_change) begin
      frame_cnt_q <= '0;
    end else if (frame_tick && !(&frame_cnt_q)) begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  // Evolution owed: latched during battle, consumed when evolve ends.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      evo_pending_q <= 1'b0;
    end else if (state_q == ST_EVOLVE && state_change) begin
      evo_pending_q <= 1'b0;
    end else if (state_q == ST_BATTLE && evolve_req_in) begin
      evo_pending_q <= 1'b1;
    end
  end

  // Sticky watchdog flag: records that an animation state was force-exited.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      timeout_out <= 1'b0;
    end else if (wd_fire && is_anim_state(state_q)) begin
      timeout_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_game_state_sequencer.sv
// Self-checking bench for game_state_sequencer: a frame-level behavioural
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_game_state_sequencer;

  localparam int TO = 4;

  localparam logic [2:0] S_OW = 3'b001;
  localparam logic [2:0] S_TR = 3'b010;
  localparam logic [2:0] S_BA = 3'b100;
  localparam logic [2:0] S_EV = 3'b011;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        encounter_in, battle_over_in, evolve_req_in;
  logic        trans_done_in, evo_done_in;
  logic [2:0]  state_out;
  logic        trans_start_out, evo_start_out, frame_tick_out, timeout_out;

  int n_checks = 0;
  int n_errors = 0;

  game_state_sequencer #(.TIMEOUT_FRAMES(TO), .FRAME_CNT_W(8)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .encounter_in    (encounter_in),
    .battle_over_in  (battle_over_in),
    .evolve_req_in   (evolve_req_in),
    .trans_done_in   (trans_done_in),
    .evo_done_in     (evo_done_in),
    .state_out       (state_out),
    .trans_start_out (trans_start_out),
    .evo_start_out   (evo_start_out),
    .frame_tick_out  (frame_tick_out),
    .timeout_out     (timeout_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [2:0] m_state   = S_OW;
  int         m_frames  = 0;
  logic       m_pending = 1'b0;
  logic       m_timeout = 1'b0;
  logic       m_tick    = 1'b0;
  logic       m_prev    = 1'b0;

  function automatic logic origin_now();
    return (hcount_in == 0) && (vcount_in == 0);
  endfunction

  function automatic logic [2:0] model_next(input logic [2:0] s, input int frames,
                                            input logic pend);
    logic [2:0] n;
    n = s;
    if (s == S_OW) begin
      if (encounter_in) n = S_TR;
    end else if (s == S_TR) begin
      if ((trans_done_in && frames >= 1) || frames == TO) n = S_BA;
    end else if (s == S_BA) begin
      if (battle_over_in) n = (pend || evolve_req_in) ? S_EV : S_OW;
    end else if (s == S_EV) begin
      if ((evo_done_in && frames >= 1) || frames == TO) n = S_OW;
    end else begin
      n = S_OW;
    end
    return n;
  endfunction

  function automatic logic model_wd(input logic [2:0] s, input int frames);
    logic done_ok;
    done_ok = (s == S_TR) ? (trans_done_in && frames >= 1) :
              (s == S_EV) ? (evo_done_in && frames >= 1) : 1'b1;
    return ((s == S_TR) || (s == S_EV)) && !done_ok && (frames == TO);
  endfunction

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      m_state   <= S_OW;
      m_frames  <= 0;
      m_pending <= 1'b0;
      m_timeout <= 1'b0;
      m_tick    <= 1'b0;
      m_prev    <= 1'b0;
    end else begin
      m_state   <= model_next(m_state, m_frames, m_pending);
      m_timeout <= m_timeout | model_wd(m_state, m_frames);
      if (m_state == S_EV && model_next(m_state, m_frames, m_pending) != S_EV)
        m_pending <= 1'b0;
      else if (m_state == S_BA && evolve_req_in)
        m_pending <= 1'b1;
      if (model_next(m_state, m_frames, m_pending) != m_state)
        m_frames <= 0;
      else if (m_tick)
        m_frames <= (m_frames < 255) ? m_frames + 1 : 255;
      m_tick <= origin_now() && !m_prev;
      m_prev <= origin_now();
    end
  end

  // Compare process: DUT against the model on every falling edge.
  always @(negedge clk_in) begin
    check("state_out",  {29'd0, state_out},     {29'd0, m_state});
    check("trans_start", {31'd0, trans_start_out}, {31'd0, m_state == S_TR});
    check("evo_start",  {31'd0, evo_start_out}, {31'd0, m_state == S_EV});
    check("frame_tick", {31'd0, frame_tick_out}, {31'd0, m_tick});
    check("timeout",    {31'd0, timeout_out},   {31'd0, m_timeout});
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  // One short frame: raster origin for one cycle, then three other pixels.
  task automatic frame();
    hcount_in = 11'd0; vcount_in = 10'd0;
    cycle();
    hcount_in = 11'd5;
    repeat (3) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int ticks;
    rst_n_in = 1'b0;
    hcount_in = 11'd5; vcount_in = 10'd0;
    encounter_in = 0; battle_over_in = 0; evolve_req_in = 0;
    trans_done_in = 0; evo_done_in = 0;
    repeat (2) cycle();
    check("rst_state",   {29'd0, state_out}, 32'h1);
    check("rst_trans",   {31'd0, trans_start_out}, 32'h0);
    check("rst_evo",     {31'd0, evo_start_out}, 32'h0);
    check("rst_tick",    {31'd0, frame_tick_out}, 32'h0);
    check("rst_timeout", {31'd0, timeout_out}, 32'h0);
    rst_n_in = 1'b1;
    cycle();

    // Encounter; sticky trans_done ignored until the first frame tick.
    encounter_in = 1; trans_done_in = 1;
    cycle();
    encounter_in = 0;
    check("enc_state", {29'd0, state_out}, 32'h2);
    check("enc_start", {31'd0, trans_start_out}, 32'h1);
    repeat (3) cycle();
    check("stale_done_ignored", {29'd0, state_out}, 32'h2);
    hcount_in = 0; vcount_in = 0;
    cycle();
    check("first_tick", {31'd0, frame_tick_out}, 32'h1);
    hcount_in = 5;
    cycle();
    check("min_dwell", {29'd0, state_out}, 32'h2);
    cycle();
    check("done_to_battle", {29'd0, state_out}, 32'h4);
    check("done_start_drop", {31'd0, trans_start_out}, 32'h0);
    trans_done_in = 0;

    // Battle over without evolution; stray done pulses do nothing.
    battle_over_in = 1;
    cycle();
    battle_over_in = 0;
    check("battle_to_ow", {29'd0, state_out}, 32'h1);
    trans_done_in = 1; evo_done_in = 1;
    repeat (3) cycle();
    check("ow_ignores_done", {29'd0, state_out}, 32'h1);
    trans_done_in = 0; evo_done_in = 0;

    // Done and watchdog expiry in the same cycle: done wins.
    encounter_in = 1;
    cycle();
    encounter_in = 0;
    repeat (3) frame();
    hcount_in = 0; vcount_in = 0;
    cycle();
    hcount_in = 5;
    cycle();
    check("pre_tie_state", {29'd0, state_out}, 32'h2);
    trans_done_in = 1;
    cycle();
    trans_done_in = 0;
    check("tie_state", {29'd0, state_out}, 32'h4);
    check("tie_no_timeout", {31'd0, timeout_out}, 32'h0);

    // Evolve request with battle over in the same cycle.
    evolve_req_in = 1; battle_over_in = 1;
    cycle();
    evolve_req_in = 0; battle_over_in = 0;
    check("evo_state", {29'd0, state_out}, 32'h3);
    check("evo_start", {31'd0, evo_start_out}, 32'h1);
    evo_done_in = 1;
    repeat (2) cycle();
    check("evo_stale_done", {29'd0, state_out}, 32'h3);
    hcount_in = 0; vcount_in = 0;
    cycle();
    hcount_in = 5;
    cycle();
    cycle();
    evo_done_in = 0;
    check("evo_done_to_ow", {29'd0, state_out}, 32'h1);
    check("evo_start_drop", {31'd0, evo_start_out}, 32'h0);

    // evo_pending must have been cleared: plain battle end returns to overworld.
    encounter_in = 1;
    cycle();
    encounter_in = 0;
    frame();
    trans_done_in = 1;
    cycle();
    trans_done_in = 0;
    check("second_battle", {29'd0, state_out}, 32'h4);
    battle_over_in = 1;
    cycle();
    battle_over_in = 0;
    check("pending_cleared", {29'd0, state_out}, 32'h1);

    // Transition watchdog: no done, exits one cycle after the 4th tick lands.
    encounter_in = 1;
    cycle();
    encounter_in = 0;
    repeat (3) frame();
    hcount_in = 0; vcount_in = 0;
    cycle();
    check("fourth_tick", {31'd0, frame_tick_out}, 32'h1);
    hcount_in = 5;
    cycle();
    check("wd_not_yet", {29'd0, state_out}, 32'h2);
    cycle();
    check("wd_to_battle", {29'd0, state_out}, 32'h4);
    check("wd_timeout_set", {31'd0, timeout_out}, 32'h1);

    // Pending set early in battle, then evolve watchdog back to overworld.
    evolve_req_in = 1;
    cycle();
    evolve_req_in = 0;
    repeat (2) cycle();
    battle_over_in = 1;
    cycle();
    battle_over_in = 0;
    check("pending_to_evo", {29'd0, state_out}, 32'h3);
    repeat (4) frame();
    cycle();
    check("evo_wd_to_ow", {29'd0, state_out}, 32'h1);
    check("timeout_sticky", {31'd0, timeout_out}, 32'h1);

    // Asynchronous reset in the middle of a transition.
    encounter_in = 1;
    cycle();
    encounter_in = 0;
    check("pre_reset_tr", {29'd0, state_out}, 32'h2);
    #2 rst_n_in = 1'b0;
    #1;
    check("async_rst_state", {29'd0, state_out}, 32'h1);
    check("async_rst_start", {31'd0, trans_start_out}, 32'h0);
    check("async_rst_timeout", {31'd0, timeout_out}, 32'h0);
    encounter_in = 1;
    repeat (2) cycle();
    check("enc_in_reset", {29'd0, state_out}, 32'h1);
    encounter_in = 0;
    rst_n_in = 1'b1;
    cycle();
    check("post_reset", {29'd0, state_out}, 32'h1);

    // Raster origin held for 5 cycles gives exactly one tick.
    ticks = 0;
    hcount_in = 0; vcount_in = 0;
    repeat (5) begin
      cycle();
      ticks += int'(frame_tick_out);
    end
    hcount_in = 5;
    repeat (2) begin
      cycle();
      ticks += int'(frame_tick_out);
    end
    check("one_tick_per_hold", ticks, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
